// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory word address,
// and the IF/ID pipeline register (instruction, PC, delay-slot flag,
// fetch exception code, valid).
// Optional fetch-fault (AdEL) detection is enabled by defining IF_ADEL_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_3180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_3ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        id_is_jump,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_bd,
  output logic [4:0]  id_exccode,
  output logic        id_valid
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] idpc_q, idpc_d;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic        valid_q, valid_d;

  logic        fetch_fault;
  logic        flush;

`ifdef IF_ADEL_CHECK_EN
  // Misaligned or outside the text window: the fetched word is discarded.
  always_comb begin
    fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
  end
`else
  // No fetch-address checking in this build.
  always_comb begin
    fetch_fault = 1'b0;
  end
`endif

  // Next-PC selection: exception > eret > stall > redirect > sequential.
  always_comb begin
    flush = exc_req || eret_req;
    pc_d  = pc_q + 32'd4;
    if (exc_req) begin
      pc_d = HANDLER_PC;
    end else if (eret_req) begin
      pc_d = epc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (redirect_en) begin
      pc_d = redirect_pc;
    end
  end

  // IF/ID next state: flush on exception/eret, hold on stall, else capture.
  always_comb begin
    instr_d = instr_q;
    idpc_d  = idpc_q;
    bd_d    = bd_q;
    code_d  = code_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = '0;
      idpc_d  = '0;
      bd_d    = 1'b0;
      code_d  = EXC_NONE;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = fetch_fault ? '0 : imem_rdata;
      idpc_d  = pc_q;
      bd_d    = id_is_jump;
      code_d  = fetch_fault ? EXC_ADEL : EXC_NONE;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      idpc_q  <= '0;
      bd_q    <= 1'b0;
      code_q  <= EXC_NONE;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      idpc_q  <= idpc_d;
      bd_q    <= bd_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr  = pc_q[13:2];
  assign pc_f       = pc_q;
  assign id_instr   = instr_q;
  assign id_pc      = idpc_q;
  assign id_bd      = bd_q;
  assign id_exccode = code_q;
  assign id_valid   = valid_q;

endmodule
